// File: rtl/aes_shiftrow_stream.sv
// ---------------------------------------------------------------------------
// aes_shiftrow_stream
//
// Streaming ShiftRows stage for the AES datapath used by the RISC-V AES
// custom instructions. A 128-bit state arrives as four 32-bit column words,
// is parked in one bank of a two-bank ping-pong store, and leaves as four
// ShiftRows-permuted column words. While one bank drains, the other can
// fill, so a continuous stream runs at one word per cycle.
//
// Parameters
//   INV      0 = forward ShiftRows (encrypt), 1 = inverse ShiftRows (decrypt)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   flush    synchronous abort, discards everything buffered
//   s_valid  input column valid
//   s_ready  unit can accept an input column this cycle
//   s_data   input column, [7:0]=row0 .. [31:24]=row3
//   m_valid  output column valid
//   m_ready  downstream accepts the output column
//   m_data   permuted output column, same byte/row layout as s_data
//   m_last   marks the fourth (column 3) output word of a state
// ---------------------------------------------------------------------------
module aes_shiftrow_stream #(
  parameter bit INV = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
);

  logic [31:0] bank [2][4];
  logic [1:0]  full;
  logic [1:0]  full_nxt;
  logic        wr_bank;
  logic [1:0]  wr_col;
  logic        rd_bank;
  logic [1:0]  rd_col;

  logic        s_fire;
  logic        m_fire;
  logic        fill_done;
  logic        drain_done;

  logic [31:0] perm;
  logic [1:0]  src_col;
  logic [31:0] src_word;

  // Both handshakes are driven purely from registered flags, so there is no
  // combinational path from m_ready to s_ready. A flush cycle suppresses both
  // transfers so nothing half-lands in the store while it is being cleared.
  assign s_ready    = !full[wr_bank];
  assign m_valid    = full[rd_bank];
  assign m_last     = m_valid && (rd_col == 2'd3);
  assign s_fire     = s_valid && s_ready && !flush;
  assign m_fire     = m_valid && m_ready && !flush;
  assign fill_done  = s_fire && (wr_col == 2'd3);
  assign drain_done = m_fire && (rd_col == 2'd3);

  // Next-state of the bank-full flags. Filling always targets an empty bank
  // and draining always targets a full one, so when a state completes on the
  // input side in the same cycle another finishes draining, the two updates
  // land on different bits and both take effect.
  always_comb begin
    full_nxt = full;
    if (fill_done) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (drain_done) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  // Pointer and flag registers. Reset and flush both return everything to
  // empty with both pointers at bank 0, column 0; any partially written or
  // partially drained state is simply forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_col  <= 2'd0;
      rd_bank <= 1'b0;
      rd_col  <= 2'd0;
    end else if (flush) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_col  <= 2'd0;
      rd_bank <= 1'b0;
      rd_col  <= 2'd0;
    end else begin
      full <= full_nxt;
      if (s_fire) begin
        wr_col <= wr_col + 2'd1;
        if (wr_col == 2'd3) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (m_fire) begin
        rd_col <= rd_col + 2'd1;
        if (rd_col == 2'd3) begin
          rd_bank <= ~rd_bank;
        end
      end
    end
  end

  // Column storage. The data itself never needs resetting because the full
  // flags decide whether anything in a bank is meaningful.
  always_ff @(posedge clk) begin
    if (s_fire) begin
      bank[wr_bank][wr_col] <= s_data;
    end
  end

  // ShiftRows permutation of the bank being drained. Row r of output column c
  // comes from column c+r (forward) or c-r (inverse), modulo 4; the 2-bit
  // column arithmetic wraps naturally. The result is zeroed whenever no
  // output is being presented so idle cycles never leak stale state bytes.
  always_comb begin
    perm     = '0;
    src_col  = '0;
    src_word = '0;
    for (int r = 0; r < 4; r++) begin
      if (INV) begin
        src_col = rd_col - 2'(r);
      end else begin
        src_col = rd_col + 2'(r);
      end
      src_word        = bank[rd_bank][src_col];
      perm[8*r +: 8]  = src_word[8*r +: 8];
    end
  end

  assign m_data = m_valid ? perm : 32'h0;

endmodule

// File: tb/tb_aes_shiftrow_stream.sv
// ---------------------------------------------------------------------------
// tb_aes_shiftrow_stream
//
// Drives a forward and an inverse instance with the same column stream and
// handshake. Every completed input state pushes its expected output words
// into a per-instance queue; monitors pop and compare whenever a word is
// actually transferred. Directed phases cover latency, back-to-back flow,
// backpressure, flush and asynchronous reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_aes_shiftrow_stream;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_ready;

  logic        s_ready_f, m_valid_f, m_last_f;
  logic [31:0] m_data_f;
  logic        s_ready_i, m_valid_i, m_last_i;
  logic [31:0] m_data_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          stall_cnt = 0;
  bit          rand_ready = 1'b0;

  exp_t        qf[$];
  exp_t        qi[$];
  logic [31:0] part [4];
  int          part_n = 0;
  int          xfer_cyc[$];

  bit          hold_f = 1'b0;
  bit          hold_i = 1'b0;
  logic [31:0] hold_d_f, hold_d_i;

  aes_shiftrow_stream #(.INV(1'b0)) dut_fwd (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready_f),
    .s_data  (s_data),
    .m_valid (m_valid_f),
    .m_ready (m_ready),
    .m_data  (m_data_f),
    .m_last  (m_last_f)
  );

  aes_shiftrow_stream #(.INV(1'b1)) dut_inv (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready_i),
    .s_data  (s_data),
    .m_valid (m_valid_i),
    .m_ready (m_ready),
    .m_data  (m_data_i),
    .m_last  (m_last_i)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference ShiftRows on a state held as a row/column byte matrix: output
  // row r, column c takes state byte (r, c+r) forward or (r, c-r) inverse.
  function automatic logic [31:0] ref_col(input logic [31:0] cols [4],
                                          input int c, input bit inv);
    logic [7:0]  st [4][4];
    logic [31:0] res;
    int          src;
    for (int cc = 0; cc < 4; cc++)
      for (int r = 0; r < 4; r++)
        st[r][cc] = cols[cc][8*r +: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
      res[8*r +: 8] = st[r][src];
    end
    return res;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input bit inv, input logic [31:0] d,
                             input logic l);
    exp_t e;
    bit   empty;
    empty = inv ? (qi.size() == 0) : (qf.size() == 0);
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL unexpected_output inv=%0d: got 0x%08h, expected none",
               inv, d);
    end else begin
      e = inv ? qi.pop_front() : qf.pop_front();
      checkValue(inv ? "inv_data" : "fwd_data", d, e.data);
      checkValue(inv ? "inv_last" : "fwd_last", {31'b0, l}, {31'b0, e.last});
    end
  endtask

  task automatic clearModel();
    qf.delete();
    qi.delete();
    part_n = 0;
  endtask

  // Forward-instance monitor: scoreboard on transfer, gating while idle,
  // and stability of a stalled word across the next edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_f = 1'b0;
    end else begin
      if (hold_f) begin
        checkValue("fwd_hold_valid", {31'b0, m_valid_f}, 32'd1);
        checkValue("fwd_hold_data", m_data_f, hold_d_f);
      end
      if (!m_valid_f) begin
        checkValue("fwd_idle_data", m_data_f, 32'h0);
        checkValue("fwd_idle_last", {31'b0, m_last_f}, 32'd0);
      end
      if (m_valid_f && m_ready && !flush) begin
        xfer_cyc.push_back(cyc);
        checkOutput(1'b0, m_data_f, m_last_f);
      end
      hold_f   = m_valid_f && !m_ready && !flush;
      hold_d_f = m_data_f;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_i = 1'b0;
    end else begin
      if (hold_i) begin
        checkValue("inv_hold_valid", {31'b0, m_valid_i}, 32'd1);
        checkValue("inv_hold_data", m_data_i, hold_d_i);
      end
      if (!m_valid_i) begin
        checkValue("inv_idle_data", m_data_i, 32'h0);
      end
      if (m_valid_i && m_ready && !flush) begin
        checkOutput(1'b1, m_data_i, m_last_i);
      end
      hold_i   = m_valid_i && !m_ready && !flush;
      hold_d_i = m_data_i;
    end
  end

  initial forever begin
    @(negedge rst_n);
    hold_f = 1'b0;
    hold_i = 1'b0;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  end

  // Offers one column after an optional idle gap and waits for acceptance.
  // Called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [31:0] w, input int gap);
    int  t;
    bit  ok;
    exp_t e;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      ok = s_ready_f && !flush;
      if (!ok) stall_cnt++;
      @(posedge clk);
      #1;
      t++;
    end
    s_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept within 200 cycles");
    end else begin
      part[part_n] = w;
      part_n++;
      if (part_n == 4) begin
        for (int c = 0; c < 4; c++) begin
          e.data = ref_col(part, c, 1'b0);
          e.last = (c == 3);
          qf.push_back(e);
          e.data = ref_col(part, c, 1'b1);
          qi.push_back(e);
        end
        part_n = 0;
      end
    end
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((qf.size() != 0 || qi.size() != 0) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkValue("drain_pending", qf.size() + qi.size(), 32'd0);
    checkValue("drain_m_valid", {31'b0, m_valid_f}, 32'd0);
  endtask

  task automatic applyVector();
    applyStimulus(32'h03020100, 0);
    applyStimulus(32'h07060504, 0);
    applyStimulus(32'h0B0A0908, 0);
    applyStimulus(32'h0F0E0D0C, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkValue("rst_s_ready", {31'b0, s_ready_f}, 32'd1);
    checkValue("rst_m_valid", {31'b0, m_valid_f}, 32'd0);
    checkValue("rst_m_last", {31'b0, m_last_f}, 32'd0);
    checkValue("rst_m_data", m_data_f, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector, forward and inverse, with latency.
    $display("[TB] directed vector");
    m_ready = 1'b1;
    applyStimulus(32'h03020100, 0);
    applyStimulus(32'h07060504, 0);
    applyStimulus(32'h0B0A0908, 0);
    checkValue("lat_before", {31'b0, m_valid_f}, 32'd0);
    applyStimulus(32'h0F0E0D0C, 0);
    checkValue("lat_valid", {31'b0, m_valid_f}, 32'd1);
    checkValue("vec_fwd_col0", m_data_f, 32'h0F0A0500);
    checkValue("vec_inv_col0", m_data_i, 32'h070A0D00);
    waitDrain();

    // Back-to-back: three states, no stalls, twelve consecutive outputs.
    $display("[TB] back-to-back");
    stall_cnt = 0;
    xfer_cyc.delete();
    for (int k = 0; k < 12; k++) applyStimulus($urandom, 0);
    waitDrain();
    checkValue("b2b_stalls", stall_cnt, 32'd0);
    checkValue("b2b_count", xfer_cyc.size(), 32'd12);
    if (xfer_cyc.size() == 12)
      checkValue("b2b_span", xfer_cyc[11] - xfer_cyc[0], 32'd11);

    // Backpressure: two states buffered, input blocked, ordered drain.
    $display("[TB] backpressure");
    m_ready = 1'b0;
    applyVector();
    checkValue("bp_ready_mid", {31'b0, s_ready_f}, 32'd1);
    for (int k = 0; k < 4; k++) applyStimulus($urandom, 0);
    checkValue("bp_ready_full", {31'b0, s_ready_f}, 32'd0);
    checkValue("bp_hold_fwd", m_data_f, 32'h0F0A0500);
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    repeat (2) begin
      @(posedge clk);
      #1;
      checkValue("bp_ready_blocked", {31'b0, s_ready_f}, 32'd0);
      checkValue("bp_hold_fwd2", m_data_f, 32'h0F0A0500);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkValue("bp_ready_3rd", {31'b0, s_ready_f}, 32'd0);
    @(posedge clk);
    #1;
    checkValue("bp_ready_4th", {31'b0, s_ready_f}, 32'd1);
    checkValue("bp_second_valid", {31'b0, m_valid_f}, 32'd1);
    waitDrain();

    // Flush with one full state partly drained and a partial state filling.
    $display("[TB] flush");
    m_ready = 1'b0;
    applyVector();
    applyStimulus($urandom, 0);
    applyStimulus($urandom, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    flush   = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    clearModel();
    checkValue("fl_m_valid", {31'b0, m_valid_f}, 32'd0);
    checkValue("fl_s_ready", {31'b0, s_ready_f}, 32'd1);
    checkValue("fl_m_last", {31'b0, m_last_f}, 32'd0);
    m_ready = 1'b1;
    applyVector();
    checkValue("fl_fresh_col0", m_data_f, 32'h0F0A0500);
    waitDrain();

    // Asynchronous reset in the middle of a drain.
    $display("[TB] async reset");
    m_ready = 1'b0;
    applyVector();
    m_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("ar_m_valid", {31'b0, m_valid_f}, 32'd0);
    checkValue("ar_m_last", {31'b0, m_last_f}, 32'd0);
    checkValue("ar_s_ready", {31'b0, s_ready_f}, 32'd1);
    checkValue("ar_m_data", m_data_f, 32'h0);
    clearModel();
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    applyVector();
    waitDrain();

    // Random traffic with random backpressure.
    $display("[TB] random");
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) applyStimulus($urandom, $urandom_range(0, 2));
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_shiftrow_stream.md
Name: aes_shiftrow_stream

Overview:
- Streaming ShiftRows unit for the AES datapath driven by the RISC-V AES custom instructions.
- Accepts the 128-bit state as four 32-bit column words over a valid/ready handshake and buffers them in a two-bank ping-pong store.
- Returns the four ShiftRows-permuted column words over a second valid/ready handshake.
- Forward direction by default (encryption side); parameter-selectable inverse so the decryption path can share the block.

Parameters:
- INV, 0: 0 = forward ShiftRows, 1 = inverse ShiftRows; fixed at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort: empties both banks and clears all pointers
- s_valid  input  1  input column word valid
- s_ready  output  1  unit can accept an input column this cycle
- s_data  input  32  input column; bits [7:0]=row0, [15:8]=row1, [23:16]=row2, [31:24]=row3
- m_valid  output  1  output column word valid
- m_ready  input  1  downstream accepts output column
- m_data  output  32  permuted output column, same byte/row layout as s_data
- m_last  output  1  high with m_valid on the 4th (column 3) output word of a state

Behaviour:
- Storage: bank[0..1], each 4 x 32-bit columns; full[1:0] flags; wr_bank, wr_col[1:0], rd_bank, rd_col[1:0].
- Reset (rst_n low, asynchronous):
  - all pointers and full flags = 0, so s_ready=1, m_valid=0, m_last=0;
  - m_data = 0 while m_valid=0 (output is gated);
  - bank contents need not be reset.
- Input handshake: s_ready = !full[wr_bank].
  - Accept when s_valid && s_ready: bank[wr_bank][wr_col] <= s_data, wr_col++.
  - On accepting wr_col==3: set full[wr_bank], toggle wr_bank, wr_col wraps to 0.
- Output handshake: m_valid = full[rd_bank]; m_last = m_valid && rd_col==3.
  - Transfer when m_valid && m_ready: rd_col++.
  - On transferring rd_col==3: clear full[rd_bank], toggle rd_bank, rd_col wraps to 0.
- Permutation, combinational from the stored bank, output column c, with B = bank[rd_bank]:
  - forward (INV=0): m_data = {B[(c+3)%4][31:24], B[(c+2)%4][23:16], B[(c+1)%4][15:8], B[c][7:0]}
  - inverse (INV=1): m_data = {B[(c+1)%4][31:24], B[(c+2)%4][23:16], B[(c+3)%4][15:8], B[c][7:0]}
- Latency: column 0 of a state is presented (m_valid=1) the cycle after its 4th input column is accepted.
- Throughput: with m_ready held high, 1 word/cycle sustained, with no bubble between states.
- Backpressure: m_valid and m_data hold stable while m_ready=0.
- Both banks full: s_ready=0 until the draining bank's column 3 transfers. s_ready rises the next cycle; no combinational m_ready->s_ready path.
- Simultaneous input fill-complete and output drain-complete in the same cycle: each acts on its own bank flag; both updates take effect.
- s_valid with s_ready=0: ignored; s_data is not captured.
- flush: has priority over both handshakes in the same cycle; next cycle equals the reset state. A partially written or partially drained state is discarded.
- Reset asserted mid-transfer: same as flush, but asynchronous.
- Exactly one state in flight per bank; at most 2 states buffered.

Test Plan:
- Forward, INV=0: input 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with m_ready=1 -> outputs 0x0F0A0500, 0x030E0904, 0x07020D08, 0x0B06010C; m_last only on the 4th; first m_valid one cycle after the 4th accept.
- Inverse, INV=1: same input -> outputs 0x070A0D00, 0x0B0E0104, 0x0F020508, 0x0306090C.
- Back-to-back: three states streamed continuously, m_ready=1 -> 12 outputs on consecutive cycles after the initial 4-cycle latency; s_ready never drops.
- Backpressure: m_ready=0 while 8 columns are offered -> s_ready drops after the 8th accept. m_data holds 0x0F0A0500. Raising m_ready drains in order, and s_ready returns the cycle after the 4th drain.
- Flush: after 2 input columns and 1 output pending, pulse flush -> next cycle m_valid=0, s_ready=1. A fresh 4-column state then produces the correct permutation starting at column 0.
- Async reset: drop rst_n mid-drain, between clock edges -> m_valid falls immediately, m_last=0, s_ready=1; normal operation resumes after release.
